// File: rtl/pair_detect_ctrl_if.sv
// Word-in / count-out handshake bundle for pair_detect_ctrl.
// The slave modport is the detector side; the master modport is the producer/consumer side.
interface pair_detect_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              carry_hist;
    logic              out_valid;
    logic              out_ready;
    logic [CNT_W-1:0]  out_count;

    modport slave (
        input  in_valid, in_data, carry_hist, out_ready,
        output in_ready, out_valid, out_count
    );

    modport master (
        output in_valid, in_data, carry_hist, out_ready,
        input  in_ready, out_valid, out_count
    );
endinterface

// File: rtl/pair_detect_ctrl.sv
// Serial detector of non-overlapping equal-bit pairs, one bit per cycle MSB-first,
// with per-word count handshake and a saturating running total.
module pair_detect_ctrl #(
    parameter int DATA_W = 8,
    parameter int TOT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    pair_detect_ctrl_if.slave    bus,
    input  logic                 clear_total,
    output logic                 det_pulse,
    output logic [TOT_W-1:0]     total,
    output logic                 busy
);
    localparam int CNT_W = $clog2(DATA_W / 2 + 1);
    localparam int IDX_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    typedef enum logic [1:0] {H_NONE, H_ONE, H_ZERO} hist_t;

    state_t            r_state;
    state_t            w_next;
    hist_t             r_hist;
    logic [DATA_W-1:0] r_data;
    logic [IDX_W-1:0]  r_idx;
    logic [CNT_W-1:0]  r_count;
    logic              r_det;
    logic [TOT_W-1:0]  r_total;

    logic w_accept;
    logic w_bit;
    logic w_match;
    logic w_last;

    function automatic logic [TOT_W-1:0] sat_inc(input logic [TOT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign w_accept = (r_state == IDLE) && bus.in_valid;
    assign w_bit    = r_data[DATA_W-1];
    assign w_last   = (r_idx == IDX_W'(DATA_W - 1));
    // A pending single of the same value completes a pair; it is then consumed.
    assign w_match  = (r_state == SHIFT) &&
                      (((r_hist == H_ONE) && w_bit) || ((r_hist == H_ZERO) && !w_bit));

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept)      w_next = SHIFT;
            SHIFT:   if (w_last)        w_next = DONE;
            DONE:    if (bus.out_ready) w_next = IDLE;
            default:                    w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_data <= bus.in_data;
            r_idx  <= '0;
        end else if (r_state == SHIFT) begin
            r_data <= r_data << 1;
            r_idx  <= r_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hist  <= H_NONE;
            r_count <= '0;
            r_det   <= 1'b0;
            r_total <= '0;
        end else begin
            r_det <= w_match;
            if (w_accept) begin
                r_count <= '0;
                if (!bus.carry_hist) r_hist <= H_NONE;
            end else if (r_state == SHIFT) begin
                if (w_match) begin
                    r_hist  <= H_NONE;
                    r_count <= r_count + 1'b1;
                end else begin
                    r_hist  <= w_bit ? H_ONE : H_ZERO;
                end
            end
            // Clear has priority over a detection landing in the same cycle.
            if (clear_total)  r_total <= '0;
            else if (w_match) r_total <= sat_inc(r_total);
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.out_count = r_count;
    assign det_pulse     = r_det;
    assign total         = r_total;
    assign busy          = (r_state != IDLE);
endmodule
